spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Single-clock SPI master front-end that sits directly upstream of the SPI slave/RAM wrapper and drives its `MOSI`/`SS_n` pins while sampling `MISO`. A host issues one 10-bit command (2-bit opcode plus 8-bit payload) per transaction. The block serializes it into the wrapper's frame format and, for read-data commands, captures the 8-bit reply. SPI bits advance once per `clk`; no separate SCK is generated, because the wrapper samples on `clk`.

## Interface
- `RD_WAIT`, default 1: turnaround cycles between the last MOSI payload bit and the first MISO sample (read-data only); legal range 0–3.
- `clk` input, 1 bit: system clock; all logic on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a transaction; accepted only in IDLE.
- `cmd` input, 2 bits: opcode. 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- `din` input, 8 bits: payload (address/data; don't-care content for 11 but still shifted).
- `MISO` input, 1 bit: serial data from slave.
- `MOSI` output, 1 bit: serial data to slave.
- `SS_n` output, 1 bit: active-low slave select.
- `busy` output, 1 bit: high from the cycle after acceptance until return to IDLE.
- `done` output, 1 bit: one-cycle pulse at end of every transaction.
- `rd_data` output, 8 bits: last captured read byte; holds until next read-data completes.
- `rd_valid` output, 1 bit: one-cycle pulse with `done` for cmd 11 only.

## Operation
- States: IDLE, SELECT, SHIFT, TURN, RECV, GAP.
- IDLE: `SS_n`=1, `MOSI`=0, `busy`=0. If `start`=1, latch `cmd`/`din` into an 11-bit shift register {cmd[1], cmd[1], cmd[0], din[7:0]} and go to SELECT. The first bit is the slave's read/write path select.
- SELECT (1 cycle): `SS_n`=0, `MOSI`=0. This gives the slave its IDLE→command-check transition.
- SHIFT (11 cycles): `MOSI` = shift-register MSB; shift left each cycle. The bit counter counts 0..10. After bit 10, cmd 11 goes to TURN (or RECV if `RD_WAIT`=0); all other cmds go to GAP.
- TURN (`RD_WAIT` cycles): `SS_n`=0, `MOSI`=0.
- RECV (8 cycles): `SS_n`=0, `MOSI`=0. At each edge ending a RECV cycle, `rd_shift` = {`rd_shift`[6:0], `MISO`}, MSB first. After the 8th sample, go to GAP.
- GAP (1 cycle): `SS_n`=1. Assert `done`. For cmd 11, also copy `rd_shift` to `rd_data` and assert `rd_valid`. Then go to IDLE.
- `start` while `busy` is ignored and not queued. `cmd`/`din` changes after acceptance have no effect.
- Bit counter is 4 bits wide and wraps only via state exit. There is no overflow path.

## Timing
- Reset values: `SS_n`=1, `MOSI`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=8'h00, state=IDLE, counters=0.
- `rst` asserted mid-frame: at the next edge, `SS_n`=1 and state=IDLE. No `done` pulse. `rd_data` is cleared to 00.
- `start` sampled high at edge N:
  - `SS_n` falls after edge N.
  - First frame bit is on `MOSI` after edge N+1.
  - Last payload bit is after edge N+11.
- Frame length with `SS_n` low: 12 cycles for cmds 00/01/10; 20+`RD_WAIT` cycles for cmd 11.
- `done` is high in the cycle following the final low-`SS_n` cycle. It is 1 cycle, with `SS_n`=1.
- Minimum `SS_n`-high gap between back-to-back frames is 2 cycles: GAP plus IDLE acceptance.
- `start` in the same cycle `done` is high is ignored. It is accepted the following cycle.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `start`=1 → `SS_n`=1, `MOSI`=0, `busy`=0, `rd_data`=00 throughout.
- Write address: `cmd`=00, `din`=8'hA5 → `MOSI` over SHIFT = 0,0,0,1,0,1,0,0,1,0,1. `SS_n` low exactly 12 cycles. Wrapper `wr_addr`=A5 after `done`.
- Write data: `cmd`=01, `din`=8'h3C following the previous case → wrapper `mem[A5]`=3C. Frame bits = 0,0,1 then 00111100.
- Read address then read data: cmd 10/A5, then cmd 11/00 with `RD_WAIT`=1 → `SS_n` low 21 cycles. `rd_valid` pulses once, with `rd_data`=3C.
- Busy rejection: pulse `start` with `cmd`=01 on every cycle of a cmd-00 frame → exactly one frame is emitted. `done` pulses once. Frame payload equals the first `din`.
- Mid-frame reset: assert `rst` during SHIFT bit 5 of a cmd-11 frame → `SS_n`=1 at the next edge. No `done`/`rd_valid`. A subsequent cmd-11 frame completes normally.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master front-end: serializes one 2-bit opcode + 8-bit payload per transaction
// into the slave wrapper's 11-bit frame and captures the 8-bit reply for read-data commands.
module spi_master_ctrl #(
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SS_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_TURN   = 3'd3;
    localparam logic [2:0] S_RECV   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    localparam logic [3:0] SHIFT_LAST = 4'd10;
    localparam logic [3:0] RECV_LAST  = 4'd7;
    localparam logic [3:0] TURN_LAST  = 4'(RD_WAIT - 1);

    logic [2:0]  state;
    logic [3:0]  bit_cnt;
    logic [10:0] tx_shift;
    logic [7:0]  rd_shift;
    logic        is_read;

    // Handshake: start is honoured only while IDLE; requests at any other time
    // are dropped, and cmd/din are copied on acceptance so later changes are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            tx_shift <= 11'd0;
            rd_shift <= 8'd0;
            rd_data  <= 8'd0;
            is_read  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_cnt <= 4'd0;
                    if (start) begin
                        // First bit duplicates cmd[1]: the slave uses it to pick its read/write path.
                        tx_shift <= {cmd[1], cmd[1], cmd[0], din};
                        is_read  <= &cmd;
                        state    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    tx_shift <= {tx_shift[9:0], 1'b0};
                    if (bit_cnt == SHIFT_LAST) begin
                        bit_cnt <= 4'd0;
                        if (!is_read)          state <= S_GAP;
                        else if (RD_WAIT == 0) state <= S_RECV;
                        else                   state <= S_TURN;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_TURN: begin
                    if (bit_cnt == TURN_LAST) begin
                        bit_cnt <= 4'd0;
                        state   <= S_RECV;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_RECV: begin
                    rd_shift <= {rd_shift[6:0], MISO};
                    if (bit_cnt == RECV_LAST) begin
                        // Publish the byte on entry to GAP so rd_data is valid alongside rd_valid.
                        rd_data <= {rd_shift[6:0], MISO};
                        bit_cnt <= 4'd0;
                        state   <= S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        busy      = (state != S_IDLE);
        done      = (state == S_GAP);
        rd_valid  = (state == S_GAP) && is_read;
        dbg_state = state;
        if (state == S_SELECT || state == S_SHIFT || state == S_TURN || state == S_RECV) begin
            SS_n = 1'b0;
        end
        if (state == S_SHIFT) begin
            MOSI = tx_shift[10];
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + randomized bench for spi_master_ctrl, with a behavioural model of the
// slave wrapper (address register + 256-byte memory) supplying read replies.
module tb_spi_master_ctrl;

    localparam int RD_WAIT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       MISO;
    logic       MOSI;
    logic       SS_n;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] dbg_state;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] mem [256];
    logic [7:0] addr_reg;
    logic [7:0] exp_rd;

    spi_master_ctrl #(.RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .din(din), .MISO(MISO),
        .MOSI(MOSI), .SS_n(SS_n), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; expected waveform derived from frame layout:
    // cycle 0 select, cycles 1..11 frame bits, then turnaround + 8 reply bits for reads,
    // then one done cycle with SS_n high. spam keeps start asserted throughout.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input bit spam);
        logic [10:0] bits;
        logic [7:0]  rbyte;
        int          len;
        int          ridx;
        bits  = {c[1], c[1], c[0], d};
        len   = (c == 2'b11) ? 20 + RD_WAIT : 12;
        rbyte = mem[addr_reg];
        @(negedge clk);
        start = 1'b1; cmd = c; din = d;
        for (int k = 0; k <= len + 1; k++) begin
            @(negedge clk);
            chk("ss_n",     SS_n,     (k < len) ? 0 : 1);
            chk("mosi",     MOSI,     (k >= 1 && k <= 11) ? bits[11 - k] : 0);
            chk("busy",     busy,     (k <= len) ? 1 : 0);
            chk("done",     done,     (k == len) ? 1 : 0);
            chk("rd_valid", rd_valid, (k == len && c == 2'b11) ? 1 : 0);
            if (k == len && c == 2'b11) exp_rd = rbyte;
            chk("rd_data",  rd_data,  exp_rd);
            start = spam && (k <= len);
            cmd   = 2'($urandom);
            din   = 8'($urandom);
            ridx  = k - (12 + RD_WAIT);
            MISO  = (c == 2'b11 && ridx >= 0 && ridx < 8) ? rbyte[7 - ridx] : 1'($urandom);
        end
        @(negedge clk);
        chk("post_ss_n", SS_n, 1);
        chk("post_busy", busy, 0);
        case (c)
            2'b00: addr_reg = d;
            2'b01: mem[addr_reg] = d;
            2'b10: addr_reg = d;
            default: ;
        endcase
    endtask

    task automatic mid_reset;
        logic [10:0] bits;
        bits = {1'b1, 1'b1, 1'b1, 8'($urandom)};
        @(negedge clk);
        start = 1'b1; cmd = 2'b11; din = bits[7:0];
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 6) begin
                chk("mr_ss_low", SS_n, 0);
                chk("mr_bit5",   MOSI, bits[5]);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        chk("mr_ss_n",     SS_n,     1);
        chk("mr_done",     done,     0);
        chk("mr_rd_valid", rd_valid, 0);
        chk("mr_busy",     busy,     0);
        chk("mr_rd_data",  rd_data,  0);
        exp_rd = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_idle_ss_n", SS_n, 1);
        chk("mr_idle_done", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        addr_reg = 8'h00;
        exp_rd   = 8'h00;
        rst = 1'b1; start = 1'b1; cmd = 2'b00; din = 8'h00; MISO = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ss_n",     SS_n,     1);
            chk("rst_mosi",     MOSI,     0);
            chk("rst_busy",     busy,     0);
            chk("rst_done",     done,     0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data",  rd_data,  0);
        end
        rst = 1'b0; start = 1'b0;

        run_frame(2'b00, 8'hA5, 1'b0);
        run_frame(2'b01, 8'h3C, 1'b0);
        run_frame(2'b10, 8'hA5, 1'b0);
        run_frame(2'b11, 8'h00, 1'b0);
        chk("plan_rd_data", rd_data, 8'h3C);

        run_frame(2'b00, 8'($urandom), 1'b1);
        run_frame(2'b11, 8'($urandom), 1'b1);

        mid_reset();
        run_frame(2'b11, 8'($urandom), 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_frame(2'($urandom), 8'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
